aclint_timer_swi: RTL and testbench
===================================

// Module: aclint_timer_swi
// PURPOSE
//  Parametrised memory-mapped machine timer and software-interrupt unit (CLINT/ACLINT style) for N harts.
//  Owns the 64-bit mtime counter, one mtimecmp per hart, and per-hart msip/ssip bits.
//  Sits on the peripheral bus. Drives mem_mtime/mem_mtimecmp/mem_msip/mem_ssip into each hart's CSR unit.
//  Adds a timebase prescaler, multi-hart support, a registered mtip output and byte-lane writes.
// PARAMETERS
//  DATA_SIZE   32      bus width, 32 or 64
//  NUM_HARTS   1       harts served, 1..16
//  ADDR_WIDTH  16      byte-offset width inside the block window
//  CLOCK_DIV   1       clock cycles per mtime tick, >=1
// PORTS
//  clock              in   1                    system clock
//  reset              in   1                    asynchronous, active-high
//  rd_en              in   1                    read request
//  wr_en              in   1                    write request
//  addr               in   ADDR_WIDTH           byte offset, DATA_SIZE/8-aligned
//  wr_data            in   DATA_SIZE            write data
//  byte_write_enable  in   DATA_SIZE/8          per-byte write strobes
//  rd_data            out  DATA_SIZE            read data, valid with ack
//  ack                out  1                    one-cycle completion pulse
//  mem_mtime          out  64                   current mtime
//  mem_mtimecmp       out  64*NUM_HARTS         hart h at bits [64h+63:64h]
//  mem_msip           out  NUM_HARTS            machine software interrupt pending
//  mem_ssip           out  NUM_HARTS            supervisor software interrupt pending
//  mtip               out  NUM_HARTS            registered (mtime >= mtimecmp[h])
// BEHAVIOUR
//  Reset values:
//   - mtime=0, every mtimecmp=all-ones, msip=ssip=0, mtip=0, ack=0, rd_data=0, prescaler=0.
//  Address map (32-bit lanes):
//   - msip[h]      at 0x0000+4h
//   - mtimecmp[h]  at 0x4000+8h (low word), +4 (high word)
//   - mtime        at 0xBFF8 (low word), 0xBFFC (high word)
//   - ssip[h]      at 0xC000+4h
//   - msip/ssip: bit0 writable; bits 31:1 read 0.
//  Lane mapping for DATA_SIZE=64:
//   - lane k (bytes 4k..4k+3) maps to offset addr+4k. One access reads/writes a full 64-bit register.
//  Handshake:
//   - A request is accepted on any cycle with rd_en|wr_en while FSM is IDLE.
//   - FSM: IDLE -> ACK on request; ACK -> IDLE unconditionally.
//   - ack=1 only in ACK. Latency is exactly 1 cycle. Requests presented during ACK are ignored.
//   - Address, data and strobes are registered at acceptance. rd_data updates only on read acks and holds otherwise.
//   - rd_en & wr_en together: the write is performed, ack is given, rd_data is unchanged.
//   - Unmapped offsets and harts >= NUM_HARTS: writes dropped, reads return 0, ack still given.
//   - Writes apply only bytes with byte_write_enable=1.
//  Timebase:
//   - The prescaler counts 0..CLOCK_DIV-1. mtime increments by 1 on the cycle the prescaler wraps.
//   - With CLOCK_DIV=1, mtime increments every cycle.
//   - mtime wraps from 2^64-1 to 0.
//   - A bus write to any mtime byte in the ACK cycle overrides that cycle's increment for the whole register.
//     Written bytes take the new value; unwritten bytes keep their pre-increment value.
//     The prescaler resets to 0 on that write.
//  mtip:
//   - mtip[h] is registered from (mtime >= mtimecmp[h]), unsigned 64-bit compare, one cycle after either operand changes.
//   - A mtimecmp write to all-ones clears mtip[h] on the following cycle unless mtime is all-ones.
//  Reset mid-transaction: the pending ack is cancelled and all state returns to reset values.
// TESTING
//  1. Reset, CLOCK_DIV=1, idle 10 cycles -> mem_mtime==10±1 (bench fixes exact edge), mtip==0.
//  2. Write msip[0]=0xFFFFFFFF, read back -> ack exactly 1 cycle after wr_en, mem_msip[0]=1, rd_data==1.
//  3. Write mtimecmp[1]=0x20 (NUM_HARTS=2), mtime=0x1E -> mtip[1] rises when mtime first ==0x20; mtip[0] stays 0.
//  4. DATA_SIZE=32: write mtime hi=0xFFFFFFFF, lo=0xFFFFFFFE -> mtime wraps to 0 two ticks later; mtip tracks the wrap.
//  5. CLOCK_DIV=4: mtime advances 1 per 4 cycles; mtime write mid-count restarts the prescaler and loads the written value.
//  6. Read 0x8000 and ssip[NUM_HARTS] -> rd_data==0, ack given. rd_en&wr_en on ssip[0]=1 -> ssip set, rd_data unchanged.

Source files
------------

// File: rtl/aclint_timer_swi.sv
// Memory-mapped machine timer and software-interrupt unit for NUM_HARTS harts.
// Owns mtime (with prescaler), per-hart mtimecmp/msip/ssip and registered mtip.
module aclint_timer_swi #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_HARTS  = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int CLOCK_DIV  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_SIZE-1:0]      wr_data,
  input  logic [DATA_SIZE/8-1:0]    byte_write_enable,
  output logic [DATA_SIZE-1:0]      rd_data,
  output logic                      ack,
  output logic [63:0]               mem_mtime,
  output logic [64*NUM_HARTS-1:0]   mem_mtimecmp,
  output logic [NUM_HARTS-1:0]      mem_msip,
  output logic [NUM_HARTS-1:0]      mem_ssip,
  output logic [NUM_HARTS-1:0]      mtip
);

  localparam int LANES = DATA_SIZE / 32;
  localparam int BYTES = DATA_SIZE / 8;
  localparam int PW    = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  localparam logic [31:0] MSIP_BASE     = 32'h0000;
  localparam logic [31:0] MTIMECMP_BASE = 32'h4000;
  localparam logic [31:0] MTIME_LO      = 32'hBFF8;
  localparam logic [31:0] MTIME_HI      = 32'hBFFC;
  localparam logic [31:0] SSIP_BASE     = 32'hC000;

  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_next;

  logic                           accept;
  logic                           req_wr_q;
  logic [ADDR_WIDTH-1:0]          addr_aligned, addr_q;
  logic [DATA_SIZE-1:0]           wr_data_q, rd_next;
  logic [BYTES-1:0]               be_q;

  logic [63:0]                    mtime, mtime_wr;
  logic                           mtime_hit;
  logic [PW-1:0]                  prescaler;
  logic [NUM_HARTS-1:0][63:0]     mtimecmp, mtimecmp_n;
  logic [NUM_HARTS-1:0]           msip, msip_n, ssip, ssip_n;
  logic [31:0]                    rd_off, wr_off;

  assign addr_aligned = addr & ~ADDR_WIDTH'(BYTES - 1);
  assign accept       = (state == IDLE) && (rd_en || wr_en);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_en || wr_en) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack = (state == ACK);
  end

  // Read mux: each 32-bit lane decodes its own word offset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_next = '0;
    rd_off  = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_off = 32'(addr_aligned) + 32'(4 * k);
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (rd_off == MSIP_BASE + 32'(4 * h))              rd_next[32*k]     = msip[h];
        if (rd_off == SSIP_BASE + 32'(4 * h))              rd_next[32*k]     = ssip[h];
        if (rd_off == MTIMECMP_BASE + 32'(8 * h))          rd_next[32*k+:32] = mtimecmp[h][31:0];
        if (rd_off == MTIMECMP_BASE + 32'(8 * h) + 32'd4)  rd_next[32*k+:32] = mtimecmp[h][63:32];
      end
      if (rd_off == MTIME_LO) rd_next[32*k+:32] = mtime[31:0];
      if (rd_off == MTIME_HI) rd_next[32*k+:32] = mtime[63:32];
    end
  end

  // Write merge for the accepted request, applied at the end of the ACK cycle.
  always_comb begin
    msip_n     = msip;
    ssip_n     = ssip;
    mtimecmp_n = mtimecmp;
    mtime_wr   = mtime;
    mtime_hit  = 1'b0;
    wr_off     = '0;
    if (state == ACK && req_wr_q) begin
      for (int k = 0; k < LANES; k++) begin
        wr_off = 32'(addr_q) + 32'(4 * k);
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (wr_off == MSIP_BASE + 32'(4 * h) && be_q[4*k]) msip_n[h] = wr_data_q[32*k];
          if (wr_off == SSIP_BASE + 32'(4 * h) && be_q[4*k]) ssip_n[h] = wr_data_q[32*k];
          for (int b = 0; b < 4; b++) begin
            if (be_q[4*k+b]) begin
              if (wr_off == MTIMECMP_BASE + 32'(8 * h))
                mtimecmp_n[h][8*b+:8] = wr_data_q[32*k+8*b+:8];
              if (wr_off == MTIMECMP_BASE + 32'(8 * h) + 32'd4)
                mtimecmp_n[h][32+8*b+:8] = wr_data_q[32*k+8*b+:8];
            end
          end
        end
        for (int b = 0; b < 4; b++) begin
          if (be_q[4*k+b] && wr_off == MTIME_LO) begin
            mtime_wr[8*b+:8] = wr_data_q[32*k+8*b+:8];
            mtime_hit        = 1'b1;
          end
          if (be_q[4*k+b] && wr_off == MTIME_HI) begin
            mtime_wr[32+8*b+:8] = wr_data_q[32*k+8*b+:8];
            mtime_hit           = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_wr_q  <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      be_q      <= '0;
      rd_data   <= '0;
    end else if (accept) begin
      req_wr_q  <= wr_en;
      addr_q    <= addr_aligned;
      wr_data_q <= wr_data;
      be_q      <= byte_write_enable;
      if (rd_en && !wr_en) rd_data <= rd_next;
    end
  end

  // A bus write to mtime wins over the tick and restarts the prescaler.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime     <= '0;
      prescaler <= '0;
      mtimecmp  <= '1;
      msip      <= '0;
      ssip      <= '0;
      mtip      <= '0;
    end else begin
      msip     <= msip_n;
      ssip     <= ssip_n;
      mtimecmp <= mtimecmp_n;
      if (mtime_hit) begin
        mtime     <= mtime_wr;
        prescaler <= '0;
      end else if (prescaler == PW'(CLOCK_DIV - 1)) begin
        mtime     <= mtime + 64'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
      for (int h = 0; h < NUM_HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);
    end
  end

  assign mem_mtime    = mtime;
  assign mem_mtimecmp = mtimecmp;
  assign mem_msip     = msip;
  assign mem_ssip     = ssip;

endmodule

// File: tb/tb_aclint_timer_swi.sv
// Bench for aclint_timer_swi: two instances (32-bit/2 harts/div 1 and 64-bit/3 harts/div 4)
// checked every cycle against a word-level behavioural model, plus directed literal checks.
module tb_aclint_timer_swi;

  logic clock, reset;

  logic        rd0, wr0, ack0;
  logic [15:0] addr0;
  logic [31:0] wd0, rdd0;
  logic [3:0]  be0;
  logic [63:0] mt0;
  logic [127:0] cmp0;
  logic [1:0]  msip0, ssip0, mtip0;

  logic        rd1, wr1, ack1;
  logic [15:0] addr1;
  logic [63:0] wd1, rdd1;
  logic [7:0]  be1;
  logic [63:0] mt1;
  logic [191:0] cmp1;
  logic [2:0]  msip1, ssip1, mtip1;

  aclint_timer_swi #(.DATA_SIZE(32), .NUM_HARTS(2), .ADDR_WIDTH(16), .CLOCK_DIV(1)) u_dut0 (
    .clock(clock), .reset(reset), .rd_en(rd0), .wr_en(wr0), .addr(addr0), .wr_data(wd0),
    .byte_write_enable(be0), .rd_data(rdd0), .ack(ack0), .mem_mtime(mt0),
    .mem_mtimecmp(cmp0), .mem_msip(msip0), .mem_ssip(ssip0), .mtip(mtip0));

  aclint_timer_swi #(.DATA_SIZE(64), .NUM_HARTS(3), .ADDR_WIDTH(16), .CLOCK_DIV(4)) u_dut1 (
    .clock(clock), .reset(reset), .rd_en(rd1), .wr_en(wr1), .addr(addr1), .wr_data(wd1),
    .byte_write_enable(be1), .rd_data(rdd1), .ack(ack1), .mem_mtime(mt1),
    .mem_mtimecmp(cmp1), .mem_msip(msip1), .mem_ssip(ssip1), .mtip(mtip1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit checks_on = 1'b0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (word-level register file) ----------------
  function automatic int nh(input int i);    return (i == 0) ? 2 : 3; endfunction
  function automatic int lanes(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int cd(input int i);    return (i == 0) ? 1 : 4; endfunction

  logic [63:0] mt   [2];
  int          ps   [2];
  logic [63:0] cmpv [2][4];
  bit          msp  [2][4];
  bit          ssp  [2][4];
  bit          mtp  [2][4];
  bit          busy [2];
  bit          p_wr [2];
  logic [15:0] p_addr [2];
  logic [63:0] p_wd [2];
  logic [7:0]  p_be [2];
  logic [63:0] rdv  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mt[i] = '0; ps[i] = 0; busy[i] = 0; p_wr[i] = 0; p_addr[i] = '0;
      p_wd[i] = '0; p_be[i] = '0; rdv[i] = '0;
      for (int h = 0; h < 4; h++) begin
        cmpv[i][h] = '1; msp[i][h] = 0; ssp[i][h] = 0; mtp[i][h] = 0;
      end
    end
  endtask

  function automatic logic [31:0] model_read(input int i, input int unsigned off);
    if (off < 4 * nh(i)) return {31'b0, msp[i][off/4]};
    if (off >= 'h4000 && off < 'h4000 + 8 * nh(i))
      return cmpv[i][(off - 'h4000) / 8][(off % 8) * 8 +: 32];
    if (off == 'hBFF8) return mt[i][31:0];
    if (off == 'hBFFC) return mt[i][63:32];
    if (off >= 'hC000 && off < 'hC000 + 4 * nh(i)) return {31'b0, ssp[i][(off - 'hC000) / 4]};
    return 32'h0;
  endfunction

  task automatic model_write(input int i, input int unsigned off, input logic [31:0] d,
                             input logic [3:0] b, inout logic [63:0] nt, inout bit hit);
    int unsigned h;
    if (off < 4 * nh(i)) begin
      if (b[0]) msp[i][off/4] = d[0];
    end else if (off >= 'h4000 && off < 'h4000 + 8 * nh(i)) begin
      h = (off - 'h4000) / 8;
      for (int bb = 0; bb < 4; bb++)
        if (b[bb]) cmpv[i][h][(off % 8) * 8 + 8 * bb +: 8] = d[8*bb +: 8];
    end else if (off == 'hBFF8 || off == 'hBFFC) begin
      for (int bb = 0; bb < 4; bb++)
        if (b[bb]) begin
          nt[(off - 'hBFF8) * 8 + 8 * bb +: 8] = d[8*bb +: 8];
          hit = 1;
        end
    end else if (off >= 'hC000 && off < 'hC000 + 4 * nh(i)) begin
      if (b[0]) ssp[i][(off - 'hC000) / 4] = d[0];
    end
  endtask

  task automatic model_step(input int i, input bit rd, input bit wr, input logic [15:0] a,
                            input logic [63:0] d, input logic [7:0] be);
    logic [63:0] nt;
    bit hit;
    bit nm [4];
    for (int h = 0; h < 4; h++) nm[h] = (h < nh(i)) && (mt[i] >= cmpv[i][h]);
    nt  = mt[i];
    hit = 0;
    if (busy[i]) begin
      if (p_wr[i])
        for (int k = 0; k < lanes(i); k++)
          model_write(i, int'(p_addr[i]) + 4 * k, p_wd[i][32*k +: 32], p_be[i][4*k +: 4], nt, hit);
      busy[i] = 0;
    end else if (rd || wr) begin
      if (rd && !wr) begin
        rdv[i] = '0;
        for (int k = 0; k < lanes(i); k++) rdv[i][32*k +: 32] = model_read(i, int'(a) + 4 * k);
      end
      busy[i] = 1; p_wr[i] = wr; p_addr[i] = a; p_wd[i] = d; p_be[i] = be;
    end
    if (hit) begin
      mt[i] = nt;
      ps[i] = 0;
    end else begin
      ps[i]++;
      if (ps[i] == cd(i)) begin
        ps[i] = 0;
        mt[i] = mt[i] + 64'd1;
      end
    end
    for (int h = 0; h < 4; h++) mtp[i][h] = nm[h];
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else begin
      model_step(0, rd0, wr0, addr0, {32'b0, wd0}, {4'b0, be0});
      model_step(1, rd1, wr1, addr1, wd1, be1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (checks_on) begin
      check("ack0",   ack0,  busy[0]);
      check("rd0",    rdd0,  rdv[0]);
      check("mtime0", mt0,   mt[0]);
      check("cmp0",   cmp0,  {cmpv[0][1], cmpv[0][0]});
      check("msip0",  msip0, {msp[0][1], msp[0][0]});
      check("ssip0",  ssip0, {ssp[0][1], ssp[0][0]});
      check("mtip0",  mtip0, {mtp[0][1], mtp[0][0]});
      check("ack1",   ack1,  busy[1]);
      check("rd1",    rdd1,  rdv[1]);
      check("mtime1", mt1,   mt[1]);
      check("cmp1",   cmp1,  {cmpv[1][2], cmpv[1][1], cmpv[1][0]});
      check("msip1",  msip1, {msp[1][2], msp[1][1], msp[1][0]});
      check("ssip1",  ssip1, {ssp[1][2], ssp[1][1], ssp[1][0]});
      check("mtip1",  mtip1, {mtp[1][2], mtp[1][1], mtp[1][0]});
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic bus0(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] b);
    rd0 = r; wr0 = w; addr0 = a; wd0 = d; be0 = b;
    @(negedge clock);
    check("bus0_ack", ack0, 1'b1);
    rd0 = 1'b0; wr0 = 1'b0;
    @(negedge clock);
    check("bus0_ack_end", ack0, 1'b0);
  endtask

  task automatic bus1(input bit r, input bit w, input logic [15:0] a, input logic [63:0] d,
                      input logic [7:0] b);
    rd1 = r; wr1 = w; addr1 = a; wd1 = d; be1 = b;
    @(negedge clock);
    check("bus1_ack", ack1, 1'b1);
    rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clock);
    check("bus1_ack_end", ack1, 1'b0);
  endtask

  function automatic logic [15:0] pick_addr(input int i);
    logic [15:0] a;
    int s;
    s = $urandom_range(0, 11);
    case (s)
      0: a = 16'h0000;  1: a = 16'h0004;  2: a = 16'h0008;  3: a = 16'h4000;
      4: a = 16'h4004;  5: a = 16'h4008;  6: a = 16'h4010;  7: a = 16'hBFF8;
      8: a = 16'hBFFC;  9: a = 16'hC000; 10: a = 16'hC004;
      default: a = 16'($urandom);
    endcase
    return (i == 0) ? (a & ~16'h3) : (a & ~16'h7);
  endfunction

  function automatic logic [31:0] rnd32();
    return ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 48));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sel;
    reset = 1'b0;
    rd0 = 0; wr0 = 0; addr0 = '0; wd0 = '0; be0 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wd1 = '0; be1 = '0;
    #2 reset = 1'b1;
    #1 checks_on = 1'b1;
    check("rst_mtime0", mt0, 64'h0);
    check("rst_cmp0", cmp0, {128{1'b1}});
    check("rst_ack0", ack0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Idle after reset: mtime counts edges since release.
    repeat (10) @(negedge clock);
    check("t1_mtime0", mt0, 64'd10);
    check("t1_mtime1", mt1, 64'd2);
    check("t1_mtip0", mtip0, 2'b00);

    // msip write then read-back.
    bus0(0, 1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
    check("t2_msip", msip0, 2'b01);
    bus0(1, 0, 16'h0000, 32'h0, 4'h0);
    check("t2_rd", rdd0, 32'h1);

    // mtimecmp[1]=0x20, mtime=0x1E, watch mtip[1] rise.
    bus0(0, 1, 16'h4008, 32'h20, 4'hF);
    bus0(0, 1, 16'h400C, 32'h0, 4'hF);
    bus0(0, 1, 16'hBFF8, 32'h1E, 4'hF);
    check("t3_mtime_loaded", mt0, 64'h1E);
    n = 0;
    while (mt0 != 64'h20 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("t3_reach", mt0, 64'h20);
    check("t3_mtip_pre", mtip0, 2'b00);
    @(negedge clock);
    check("t3_mtip_rise", mtip0, 2'b10);

    // Wrap of mtime through all-ones.
    bus0(0, 1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    bus0(0, 1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    check("t4_loaded", mt0, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t4_mtip_a", mtip0, 2'b10);
    @(negedge clock);
    check("t4_allones", mt0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock);
    check("t4_wrap", mt0, 64'h0);
    check("t4_mtip_b", mtip0, 2'b11);
    @(negedge clock);
    check("t4_mtip_c", mtip0, 2'b00);

    // Unmapped reads, out-of-range hart, simultaneous read+write.
    bus0(1, 0, 16'h0000, 32'h0, 4'h0);
    check("t6_rd_msip", rdd0, 32'h1);
    bus0(1, 0, 16'h8000, 32'h0, 4'h0);
    check("t6_rd_unmapped", rdd0, 32'h0);
    bus0(1, 0, 16'h0000, 32'h0, 4'h0);
    bus0(1, 0, 16'hC008, 32'h0, 4'h0);
    check("t6_rd_ssip_oob", rdd0, 32'h0);
    bus0(1, 0, 16'h0000, 32'h0, 4'h0);
    bus0(1, 1, 16'hC000, 32'h1, 4'hF);
    check("t6_ssip_set", ssip0, 2'b01);
    check("t6_rd_hold", rdd0, 32'h1);

    // Reset in the middle of a transaction cancels the ack.
    rd0 = 0; wr0 = 1; addr0 = 16'hC004; wd0 = 32'h1; be0 = 4'hF;
    @(negedge clock);
    check("rst_mid_ack", ack0, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_ack_clr", ack0, 1'b0);
    check("rst_mid_ssip", ssip0, 2'b00);
    check("rst_mid_mtime", mt0, 64'h0);
    @(negedge clock);
    reset = 1'b0; wr0 = 1'b0;

    // 64-bit instance: prescaler restart on mtime write, lane mapping, byte strobes.
    repeat (2) @(negedge clock);
    bus1(0, 1, 16'hBFF8, 64'h0000_0000_0000_0100, 8'hFF);
    check("t5_loaded", mt1, 64'h100);
    repeat (3) @(negedge clock);
    check("t5_hold", mt1, 64'h100);
    @(negedge clock);
    check("t5_tick", mt1, 64'h101);
    bus1(0, 1, 16'h4010, 64'hAAAA_BBBB_CCCC_1234, 8'h03);
    check("lane_cmp2", cmp1[191:128], 64'hFFFF_FFFF_FFFF_1234);
    bus1(0, 1, 16'h0000, {32'h1, 32'h1}, 8'hFF);
    check("lane_msip01", msip1, 3'b011);
    bus1(1, 0, 16'h0000, 64'h0, 8'h00);
    check("lane_rd01", rdd1, 64'h0000_0001_0000_0001);
    bus1(0, 1, 16'h0008, {32'h1, 32'h1}, 8'hFF);
    check("lane_msip2", msip1, 3'b111);
    bus1(1, 0, 16'h0008, 64'h0, 8'h00);
    check("lane_rd2", rdd1, 64'h0000_0000_0000_0001);

    // Randomised traffic on both instances, including requests during ACK.
    for (int c = 0; c < 2500; c++) begin
      sel = $urandom_range(0, 5);
      rd0 = (sel == 1) || (sel == 3);
      wr0 = (sel == 2) || (sel == 3);
      addr0 = pick_addr(0);
      wd0 = rnd32();
      be0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      sel = $urandom_range(0, 5);
      rd1 = (sel == 1) || (sel == 3);
      wr1 = (sel == 2) || (sel == 3);
      addr1 = pick_addr(1);
      wd1 = {rnd32(), rnd32()};
      be1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      @(negedge clock);
    end
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
